fp_byte_loader: RTL
===================

# fp_byte_loader

Byte-serial front end for the single-precision floating-point multiplier. It assembles two 32-bit operands from an 8-bit valid/ready receive stream and drives them onto the multiplier's operand inputs. It then waits out the multiplier's registered latency, captures the product, and returns it as a byte-serial valid/ready transmit stream. It sits directly upstream of the multiplier, feeding its `i_a`/`i_b`, and also consumes its `o_res`.

## Interface
- `MUL_LATENCY`, default 2: clock edges from stable operands to valid product. The multiplier registers its inputs and its output, giving 2.
- `i_clk` in 1: clock; all state updates on rising edge.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_rx_data` in 8: receive byte.
- `i_rx_valid` in 1: receive byte valid.
- `o_rx_ready` out 1: loader accepts a byte this cycle.
- `o_a` out 32: operand A to multiplier.
- `o_b` out 32: operand B to multiplier.
- `i_res` in 32: product from multiplier.
- `o_tx_data` out 8: transmit byte.
- `o_tx_valid` out 1: transmit byte valid.
- `i_tx_ready` in 1: downstream accepts the transmit byte.
- `o_busy` out 1: transaction in progress (state other than LOAD).

## Operation
- States: LOAD, WAIT, SEND.
- LOAD:
  - `o_rx_ready`=1.
  - Each handshake (`i_rx_valid & o_rx_ready`) writes the byte at index k (0..7), then increments k.
  - Bytes 0–3 are A, little-endian: byte0→`o_a[7:0]`, byte3→`o_a[31:24]`.
  - Bytes 4–7 are B, in the same order.
  - Handshake on byte 7 → WAIT; k clears and the wait counter clears.
- WAIT:
  - `o_rx_ready`=0; `o_a`/`o_b` are held.
  - The counter counts MUL_LATENCY+1 edges.
  - On the final edge, `i_res` is loaded into the result register, `o_tx_valid`=1 and `o_tx_data`=result[7:0] → SEND.
- SEND:
  - Bytes go out LSB first: 4 bytes, or 5 with the flag byte (see Configuration).
  - `o_tx_data` stays stable while `o_tx_valid & !i_tx_ready`.
  - Each handshake presents the next byte on the following cycle.
  - Handshake on the last byte → LOAD with `o_tx_valid`=0.
- RX and TX never overlap; `i_rx_valid` is ignored outside LOAD.
- Gaps in `i_rx_valid` and deasserted `i_tx_ready` stall indefinitely without losing data.
- `o_a`/`o_b` update byte-wise during LOAD. The multiplier result during LOAD is don't-care and is never captured.

## Timing
- Reset values:
  - state=LOAD, k=0.
  - `o_rx_ready`=1, `o_busy`=0.
  - `o_a`=0, `o_b`=0.
  - `o_tx_data`=0, `o_tx_valid`=0.
  - Result register=0.
- Reset mid-transaction aborts immediately. Partial operands and any pending result are discarded; all outputs return to reset values.
- `o_rx_ready` and `o_busy` decode directly from the registered state; no combinational path from `i_rx_valid`.
- `o_tx_valid` and `o_tx_data` are registered.
- Latency: byte 7 handshake at edge t → `o_tx_valid` high after edge t+MUL_LATENCY+1 (3 cycles with the default).
- Last TX handshake at edge u → `o_rx_ready`=1 after edge u. A new byte 0 can be accepted at edge u+1.
- Throughput with no stalls: 8 + MUL_LATENCY + 1 + (4 or 5) cycles per product.

## Configuration
- Macro: `FP_BYTE_LOADER_FLAG_EN`.
- When defined, the captured result is classified and a fifth TX byte {5'b0, class[2:0]} follows result byte 3. Class encoding:
  - 000 zero
  - 001 subnormal
  - 011 normal
  - 100 infinity
  - 110 NaN
- Classification rules:
  - exponent 00 with mantissa 0 → zero.
  - exponent 00 with mantissa ≠0 → subnormal.
  - exponent FF with mantissa 0 → infinity.
  - exponent FF with mantissa ≠0 → NaN.
  - Anything else → normal.
- When undefined, SEND emits exactly 4 bytes and no classifier logic exists.

## Structure
- Package `fp_byte_loader_pkg`:
  - State enum (LOAD, WAIT, SEND).
  - Class encoding constants.
  - Byte-index width (3 bits).
  - TX byte count constant, 4 or 5, selected by the macro.
- Sub-module `fp_class`: combinational 32-bit → 3-bit classifier, instantiated only under `FP_BYTE_LOADER_FLAG_EN`, on the captured result register.

## Test plan
- **Basic product.** Bench includes the real multiplier. RX 00 00 00 40 00 00 40 40 (2.0 × 3.0) → `o_a`=40000000, `o_b`=40400000; TX 00 00 C0 40, plus flag 03 if FLAG_EN. `o_tx_valid` rises exactly 3 cycles after the byte 7 handshake.
- **Special case.** RX A=7F800000, B=00000000 (inf × 0) → TX FF FF FF FF; flag 06.
- **Backpressure.** `i_tx_ready` low 5 cycles on each TX byte → each byte held stable while stalled; no byte skipped or duplicated; `o_rx_ready` stays 0 until the last handshake.
- **RX gaps.** `i_rx_valid` toggles 1/0 per cycle for 1.5 × 1.0 (3FC00000, 3F800000) → TX 00 00 C0 3F; `i_rx_valid` pulses during WAIT/SEND are ignored.
- **Reset mid-operation.** Assert `i_rst` after byte 5, then send a fresh 8-byte transaction → first transaction produces no TX, all outputs hold reset values while reset is high, and the second transaction's product is correct.
- **Back-to-back.** Three transactions with `i_tx_ready`=1 and `i_rx_valid`=1 → byte 0 of the next transaction accepted one cycle after the last TX handshake; products correct.

Source files
------------

// File: rtl/fp_byte_loader_pkg.sv
// Shared types and constants for the byte-serial multiplier front end.
// FP_BYTE_LOADER_FLAG_EN adds a fifth TX byte carrying the result class.
package fp_byte_loader_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam logic [2:0] CLASS_ZERO      = 3'b000;
  localparam logic [2:0] CLASS_SUBNORMAL = 3'b001;
  localparam logic [2:0] CLASS_NORMAL    = 3'b011;
  localparam logic [2:0] CLASS_INF       = 3'b100;
  localparam logic [2:0] CLASS_NAN       = 3'b110;

  localparam int IDX_W = 3;

`ifdef FP_BYTE_LOADER_FLAG_EN
  localparam int TX_BYTES = 5;
`else
  localparam int TX_BYTES = 4;
`endif

  localparam logic [IDX_W-1:0] TX_LAST = 3'(TX_BYTES - 1);

endpackage

// File: rtl/fp_byte_loader_if.sv
// Receive stream, multiplier operand/result lines and transmit stream of fp_byte_loader.
interface fp_byte_loader_if;
  // Valid/ready: a byte moves on a rising edge where valid and ready are both
  // high; the sender holds data stable while valid is high and ready is low.
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic [31:0] o_a;
  logic [31:0] o_b;
  logic [31:0] i_res;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_busy;

  modport master (
    output i_rx_data, i_rx_valid, i_res, i_tx_ready,
    input  o_rx_ready, o_a, o_b, o_tx_data, o_tx_valid, o_busy
  );

  modport slave (
    input  i_rx_data, i_rx_valid, i_res, i_tx_ready,
    output o_rx_ready, o_a, o_b, o_tx_data, o_tx_valid, o_busy
  );
endinterface

// File: rtl/fp_byte_loader_class.sv
// Combinational single-precision classifier (zero/subnormal/normal/inf/NaN).
// Only present when FP_BYTE_LOADER_FLAG_EN is defined.
`ifdef FP_BYTE_LOADER_FLAG_EN
module fp_class
  import fp_byte_loader_pkg::*;
(
  input  logic [31:0] value,
  output logic [2:0]  cls
);
  logic [7:0]  expo;
  logic [22:0] mant;

  assign expo = value[30:23];
  assign mant = value[22:0];

  always_comb begin
    cls = CLASS_NORMAL;
    if (expo == 8'h00)      cls = (mant == 23'd0) ? CLASS_ZERO : CLASS_SUBNORMAL;
    else if (expo == 8'hFF) cls = (mant == 23'd0) ? CLASS_INF  : CLASS_NAN;
  end
endmodule
`endif

// File: rtl/fp_byte_loader.sv
// Assembles A/B from 8 RX bytes, waits out the multiplier latency, returns the
// product LSB first. FP_BYTE_LOADER_FLAG_EN appends a class byte.
module fp_byte_loader
  import fp_byte_loader_pkg::*;
#(
  parameter int MUL_LATENCY = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  fp_byte_loader_if.slave   bus,
  output state_t            dbg_state
);
  localparam int CNT_W = $clog2(MUL_LATENCY + 2);

  state_t             state, state_n;
  logic [IDX_W-1:0]   k, tx_idx, tx_idx_nx;
  logic [CNT_W-1:0]   wait_cnt;
  logic [31:0]        a_q, b_q, res_q;
  logic [7:0]         tx_data_q, next_byte;
  logic               tx_valid_q;
  logic               rx_fire, tx_fire, wait_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= LOAD;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    rx_fire   = 1'b0;
    tx_fire   = 1'b0;
    wait_done = 1'b0;
    case (state)
      LOAD: begin
        rx_fire = bus.i_rx_valid;
        if (rx_fire && k == 3'd7) state_n = WAIT;
      end
      WAIT: begin
        wait_done = (wait_cnt == CNT_W'(MUL_LATENCY));
        if (wait_done) state_n = SEND;
      end
      SEND: begin
        tx_fire = tx_valid_q & bus.i_tx_ready;
        if (tx_fire && tx_idx == TX_LAST) state_n = LOAD;
      end
      default: state_n = LOAD;
    endcase
  end

`ifdef FP_BYTE_LOADER_FLAG_EN
  logic [2:0] res_cls;
  fp_class u_class (.value(res_q), .cls(res_cls));
`endif

  // Byte that follows the one currently presented on the TX stream.
  always_comb begin
    tx_idx_nx = tx_idx + 1'b1;
    next_byte = 8'h00;
    case (tx_idx_nx)
      3'd1: next_byte = res_q[15:8];
      3'd2: next_byte = res_q[23:16];
      3'd3: next_byte = res_q[31:24];
`ifdef FP_BYTE_LOADER_FLAG_EN
      3'd4: next_byte = {5'b0, res_cls};
`endif
      default: next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      k          <= '0;
      wait_cnt   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      tx_idx     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      case (state)
        LOAD: if (rx_fire) begin
          if (k[2]) b_q[{k[1:0], 3'b000} +: 8] <= bus.i_rx_data;
          else      a_q[{k[1:0], 3'b000} +: 8] <= bus.i_rx_data;
          k        <= k + 1'b1;
          wait_cnt <= '0;
        end
        WAIT: begin
          if (wait_done) begin
            res_q      <= bus.i_res;
            tx_data_q  <= bus.i_res[7:0];
            tx_valid_q <= 1'b1;
            tx_idx     <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        SEND: if (tx_fire) begin
          if (tx_idx == TX_LAST) begin
            tx_valid_q <= 1'b0;
          end else begin
            tx_idx    <= tx_idx_nx;
            tx_data_q <= next_byte;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_rx_ready = (state == LOAD);
  assign bus.o_busy     = (state != LOAD);
  assign bus.o_a        = a_q;
  assign bus.o_b        = b_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_valid = tx_valid_q;
  assign dbg_state      = state;
endmodule
